// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for bin2bcd_seq. chk_err exists only when
// BIN2BCD_SELFCHECK_EN is defined.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_SELFCHECK_EN
  logic                  chk_err;
`endif

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd
`ifdef BIN2BCD_SELFCHECK_EN
    , input chk_err
`endif
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd
`ifdef BIN2BCD_SELFCHECK_EN
    , output chk_err
`endif
  );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = (din >= BCD_ADD3_THRESH) ? bcd_digit_t'(din + 4'd3) : din;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, WIDTH shift steps per value.
// Optional BIN2BCD_SELFCHECK_EN adds a reconstruction check driving chk_err.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;

  // Not enough digits to hold the largest input value.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t            state_q, state_nxt;
  logic [DW-1:0]     digits_q, digits_nxt;
  logic [WIDTH-1:0]  shift_q, shift_nxt;
  logic [CW-1:0]     count_q, count_nxt;
  logic [DW-1:0]     bcd_q, bcd_nxt;
  logic              done_q, done_nxt;

  logic [DW-1:0]       corr;
  logic [DW+WIDTH-1:0] stepped;
  logic [DW-1:0]       digits_new;
  logic [WIDTH-1:0]    shift_new;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (digits_q[4*g +: 4]),
      .dout (corr[4*g +: 4])
    );
  end

  // Shift MSB of the binary register enters the units digit LSB.
  assign stepped    = {corr, shift_q} << 1;
  assign digits_new = stepped[DW+WIDTH-1:WIDTH];
  assign shift_new  = stepped[WIDTH-1:0];

  always_comb begin
    state_nxt  = state_q;
    digits_nxt = digits_q;
    shift_nxt  = shift_q;
    count_nxt  = count_q;
    bcd_nxt    = bcd_q;
    done_nxt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_nxt  = bus.bin;
          digits_nxt = '0;
          count_nxt  = CW'(WIDTH);
          state_nxt  = CONV;
        end
      end
      CONV: begin
        digits_nxt = digits_new;
        shift_nxt  = shift_new;
        count_nxt  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          bcd_nxt   = digits_new;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      digits_q <= digits_nxt;
      shift_q  <= shift_nxt;
      count_q  <= count_nxt;
      bcd_q    <= bcd_nxt;
      done_q   <= done_nxt;
    end
  end

  assign bus.busy = (state_q == CONV);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_SELFCHECK_EN
  localparam int RW = WIDTH + 4;

  logic [WIDTH-1:0] bin_q;
  logic [RW-1:0]    recon;
  logic             chk_err_q;

  always_comb begin
    recon = '0;
    for (int i = 0; i < DIGITS; i++) begin
      recon = recon + RW'(digits_new[4*i +: 4]) * RW'(pow10(i));
    end
  end

  // chk_err is updated only on the done-loading step, so it holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start) bin_q <= bus.bin;
      if (done_nxt) chk_err_q <= (recon != {4'b0000, bin_q});
    end
  end

  assign bus.chk_err = chk_err_q;

  a_selfcheck : assert property (@(posedge clk) disable iff (rst) done_q |-> !chk_err_q)
    else $error("bin2bcd_seq: reconstructed value differs from input");
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against a decimal reference model.
module tb_bin2bcd_seq;

  localparam int W = 16;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bif ();

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [4*D-1:0] last_bcd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit nib_ok(input logic [4*D-1:0] b);
    for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic convert(input logic [W-1:0] v, input bit noisy);
    int cyc, bcnt;
    bit seen, hold_ok;
    cyc = 0; bcnt = 0; seen = 1'b0; hold_ok = 1'b1;
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = v;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bif.done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      if (bif.busy) bcnt++;
      if (bif.bcd !== last_bcd) hold_ok = 1'b0;
      bif.start = noisy ? 1'($urandom) : 1'b0;
      bif.bin   = noisy ? W'($urandom) : v;
    end
    bif.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(W));
    check("busy_cycles", 32'(bcnt), 32'(W));
    check("busy_in_done", 32'(bif.busy), 32'd0);
    check("bcd_hold", 32'(hold_ok), 32'd1);
    check("bcd", 32'(bif.bcd), 32'(ref_bcd(32'(v))));
    check("nibbles", 32'(nib_ok(bif.bcd)), 32'd1);
`ifdef BIN2BCD_SELFCHECK_EN
    check("chk_err", 32'(bif.chk_err), 32'd0);
`endif
    last_bcd = ref_bcd(32'(v));
    @(negedge clk);
    check("done_pulse", 32'(bif.done), 32'd0);
  endtask

  // Start held high: each accept happens on the edge closing the previous done cycle,
  // so consecutive dones are WIDTH shift cycles plus the done cycle apart.
  task automatic back_to_back(input int n);
    logic [W-1:0] q[$];
    logic [W-1:0] b;
    int cyc, ndone;
    cyc = 0; ndone = 0;
    @(negedge clk);
    b = W'($urandom);
    bif.start = 1'b1;
    bif.bin   = b;
    q.push_back(b);
    for (int k = 0; k < n * (W + 1) + 20; k++) begin
      @(negedge clk);
      cyc++;
      if (bif.done) begin
        ndone++;
        check("b2b_bcd", 32'(bif.bcd), 32'(ref_bcd(32'(q.pop_front()))));
        check("b2b_gap", 32'(cyc), 32'(W + 1));
        cyc = 0;
        if (ndone == n) begin
          bif.start = 1'b0;
          break;
        end
        b = W'($urandom);
        bif.bin = b;
        q.push_back(b);
      end else begin
        bif.bin = W'($urandom);
      end
    end
    bif.start = 1'b0;
    check("b2b_count", 32'(ndone), 32'(n));
    last_bcd = bif.bcd;
    @(negedge clk);
  endtask

  task automatic reset_mid_conv();
    int ndone;
    ndone = 0;
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = 16'd54321;
    @(posedge clk);
    @(negedge clk);
    bif.start = 1'b0;
    repeat (6) @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_bcd", 32'(bif.bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_bcd = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bif.done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);
    convert(16'd42, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    bif.start = 1'b0;
    bif.bin   = '0;
    #12;
    check("reset_busy", 32'(bif.busy), 32'd0);
    check("reset_done", 32'(bif.done), 32'd0);
    check("reset_bcd", 32'(bif.bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_bcd = '0;

    convert(16'd0, 1'b0);
    convert(16'd1240, 1'b0);
    convert(16'd15356, 1'b1);
    convert(16'd3222, 1'b1);
    convert(16'd65535, 1'b0);
    convert(16'd9, 1'b0);
    convert(16'd10, 1'b1);
    convert(16'd99, 1'b0);
    convert(16'd100, 1'b1);
    for (int i = 0; i < 30; i++) convert(W'($urandom), 1'b1);

    back_to_back(6);
    reset_mid_conv();

`ifdef BIN2BCD_SELFCHECK_EN
    convert(16'd0, 1'b0);
    convert(16'd65535, 1'b0);
    for (int i = 0; i < 200; i++) convert(W'($urandom), 1'b0);
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      bif.start = 1'b1;
      bif.bin   = 16'd500;
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      repeat (8) @(negedge clk);
      force dut.digits_q = 20'h00009;
      @(negedge clk);
      release dut.digits_q;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bif.done) begin
          seen = 1;
          break;
        end
      end
      check("force_done", 32'(seen), 32'd1);
      check("force_chk_err", 32'(bif.chk_err), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_bcd = '0;
      convert(16'd777, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
